decode_fwd: RTL and testbench
=============================

Name: decode_fwd

Overview:
Parametrised RV32I decode/operand-fetch stage with a valid/ready handshake on both sides. It sits between fetch and execute. It forwards results from the EX and MEM stages and generates load-use interlocks internally. It also performs full illegal-instruction checking on funct fields and keeps a saturating hazard-stall counter.

Parameters:
XLEN, 32, register/operand data width (sign-extension fills to XLEN)
ADDR_W, 32, PC width
EX_W, 4, exception code width
EX_ILLEGAL, 2, exception code emitted for illegal instructions
FWD_EN, 1, 1 = forward EX/MEM results; 0 = interlock on any EX/MEM dependency
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode accepts this cycle
pc_in  in  ADDR_W  instruction PC
instr_in  in  32  instruction word
exc_in  in  EX_W  upstream exception code
exc_in_valid  in  1  upstream exception present
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts the bundle
pc_out  out  ADDR_W  registered PC
opcode  out  5  instr[6:2]
funct  out  3  instr[14:12]
variant  out  1  instr[30]
op1  out  XLEN  rs1 value (forwarded), or 0 for LUI/AUIPC/JAL
op2  out  XLEN  rs2 value or the immediate
offset  out  XLEN  B or S immediate
rd_addr  out  5  destination register; 0 for branch/store
nop_instr  out  1  NOP/FENCE marker
exc_out  out  EX_W  exception code
exc_out_valid  out  1  exception present
rs1_addr, rs2_addr  out  5 each  register-file read addresses; combinational from instr_in
rs1_data, rs2_data  in  XLEN each  register-file read data
ex_wr_en, ex_is_load  in  1 each  EX stage writes rd / EX stage is a load
ex_rd  in  5  EX destination
ex_data  in  XLEN  EX result
mem_wr_en  in  1  MEM stage writes rd
mem_rd  in  5  MEM destination
mem_data  in  XLEN  MEM result
flush  in  1  squash the stage
stall_count  out  CNT_W  hazard-stall cycles; saturates at all-ones

Behaviour:
- Reset (synchronous): out_valid=0, exc_out_valid=0, nop_instr=0, stall_count=0; every other output = 0.
- Latency: 1 cycle. A bundle accepted in cycle N is presented in cycle N+1.
- Source use: rs1 is used by OP, OP-IMM, JALR, BRANCH, LOAD, STORE. rs2 is used by OP, BRANCH, STORE. Unused sources never cause a hazard.
- hazard (combinational), asserted when any of the following holds for a used source rs with rs != 0:
  - ex_wr_en & ex_rd==rs & (ex_is_load | !FWD_EN)
  - !FWD_EN & mem_wr_en & mem_rd==rs
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept condition: in_valid & in_ready. On accept, register the decoded bundle and set out_valid=1.
- Bubble: if hazard & in_valid & (!out_valid | out_ready), set out_valid=0 that cycle and increment stall_count (saturating).
- Hold: while out_valid & !out_ready, all outputs stay bit-stable.
- Drain: if out_ready and nothing is accepted, out_valid goes to 0.
- Flush: out_valid goes to 0 next cycle. Flush takes priority over accept, hold and bubble. It does not change stall_count.
- Forwarding (FWD_EN=1), per source, in priority order:
  - src==0: value 0
  - EX match (ex_wr_en, not a load): ex_data
  - MEM match: mem_data
  - otherwise: register file data
- Immediates are sign-extended to XLEN: I, S, B (bit0=0), J (bit0=0). U is instr[31:12]<<12, sign-extended above bit 31.
- Opcode actions:
  - OP-IMM: op2 = imm_I. instr[31:7]==0 (ADDI x0,x0,0) sets nop_instr=1.
  - LUI/AUIPC: op2 = imm_U.
  - JAL: op2 = imm_J.
  - JALR: op2 = imm_I.
  - BRANCH: offset = imm_B, rd_addr=0.
  - LOAD: op2 = imm_I.
  - STORE: offset = imm_S, rd_addr=0.
  - FENCE: nop_instr=1.
- Illegal instruction → exc_out=EX_ILLEGAL, exc_out_valid=1, nop_instr=0. Illegal when any of:
  - instr[1:0] != 2'b11
  - unknown opcode
  - JALR with f3 != 0
  - BRANCH with f3 in {2,3}
  - LOAD with f3 in {3,6,7}
  - STORE with f3 > 2
  - OP with f7 not in {0, 0x20}, or f7=0x20 with f3 not in {0,5}
  - OP-IMM SLLI with f7 != 0, or SRLI/SRAI with f7 not in {0, 0x20}
- Exception priority: an incoming exc_in_valid passes through unchanged, bypassing all decode checks and hazard detection.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, op1=0, op2=5, rd_addr=1, nop_instr=0, funct=0.
- EX is a non-load writing x1 with ex_data=0xAA, MEM writes x1 with 0xBB; issue ADD x2,x1,x1 → op1=op2=0xAA, no stall.
- EX is a load to x1; issue ADD x2,x1,x0 → in_ready=0 for that cycle, one bubble (out_valid=0), stall_count=1; ex_is_load drops → accepted, out_valid=1.
- out_ready=0 for 3 cycles with a valid bundle → outputs bit-stable, in_ready=0; out_ready=1 → next instruction accepted.
- 0xFFFFFFFF, JALR with f3=1, and SUB-encoded OR (f7=0x20, f3=6) → each gives exc_out=2, exc_out_valid=1; exc_in_valid=1 with exc_in=1 → exc_out=1.
- Flush asserted together with an accept, and reset asserted mid-hold → out_valid=0 next cycle; after reset, stall_count=0.

Source files
------------

// File: rtl/decode_fwd.sv
// RV32I decode/operand-fetch stage: decodes one instruction, forwards EX/MEM results,
// interlocks on load-use hazards and registers the bundle behind a valid/ready handshake.
module decode_fwd #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int EX_W       = 4,
  parameter int EX_ILLEGAL = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  input  logic [EX_W-1:0]   exc_in,
  input  logic              exc_in_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [4:0]        opcode,
  output logic [2:0]        funct,
  output logic              variant,
  output logic [XLEN-1:0]   op1,
  output logic [XLEN-1:0]   op2,
  output logic [XLEN-1:0]   offset,
  output logic [4:0]        rd_addr,
  output logic              nop_instr,
  output logic [EX_W-1:0]   exc_out,
  output logic              exc_out_valid,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              mem_wr_en,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam bit         NO_FWD     = (FWD_EN == 0);

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [4:0]              opc_p0;
  logic [2:0]              f3_p0;
  logic [6:0]              f7_p0;
  logic                    use1_p0, use2_p0, haz1_p0, haz2_p0, hazard, illegal_p0, accept;
  logic signed [XLEN-1:0]  imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0;
  logic signed [XLEN-1:0]  fwd1_p0, fwd2_p0, op1_p0, op2_p0, offset_p0;
  logic [4:0]              rd_p0;
  logic                    nop_p0;
  logic [EX_W-1:0]         exc_p0;

  assign opc_p0   = instr_in[6:2];
  assign f3_p0    = instr_in[14:12];
  assign f7_p0    = instr_in[31:25];
  assign rs1_addr = instr_in[19:15];
  assign rs2_addr = instr_in[24:20];

  assign imm_i_p0 = sext32({{20{instr_in[31]}}, instr_in[31:20]});
  assign imm_s_p0 = sext32({{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]});
  assign imm_b_p0 = sext32({{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                            instr_in[11:8], 1'b0});
  assign imm_j_p0 = sext32({{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                            instr_in[30:21], 1'b0});
  assign imm_u_p0 = sext32({instr_in[31:12], 12'b0});

  assign use1_p0 = (opc_p0 == OPC_OP) || (opc_p0 == OPC_OPIMM) || (opc_p0 == OPC_JALR) ||
                   (opc_p0 == OPC_BRANCH) || (opc_p0 == OPC_LOAD) || (opc_p0 == OPC_STORE);
  assign use2_p0 = (opc_p0 == OPC_OP) || (opc_p0 == OPC_BRANCH) || (opc_p0 == OPC_STORE);

  assign haz1_p0 = use1_p0 && (rs1_addr != 5'd0) &&
                   ((ex_wr_en && (ex_rd == rs1_addr) && (ex_is_load || NO_FWD)) ||
                    (NO_FWD && mem_wr_en && (mem_rd == rs1_addr)));
  assign haz2_p0 = use2_p0 && (rs2_addr != 5'd0) &&
                   ((ex_wr_en && (ex_rd == rs2_addr) && (ex_is_load || NO_FWD)) ||
                    (NO_FWD && mem_wr_en && (mem_rd == rs2_addr)));
  // An upstream exception carries no operands, so it never waits on a dependency.
  assign hazard   = !exc_in_valid && (haz1_p0 || haz2_p0);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fwd1_p0 = rs1_data;
    if (rs1_addr == 5'd0) fwd1_p0 = '0;
    else if (!NO_FWD && ex_wr_en && !ex_is_load && (ex_rd == rs1_addr)) fwd1_p0 = ex_data;
    else if (!NO_FWD && mem_wr_en && (mem_rd == rs1_addr)) fwd1_p0 = mem_data;
    fwd2_p0 = rs2_data;
    if (rs2_addr == 5'd0) fwd2_p0 = '0;
    else if (!NO_FWD && ex_wr_en && !ex_is_load && (ex_rd == rs2_addr)) fwd2_p0 = ex_data;
    else if (!NO_FWD && mem_wr_en && (mem_rd == rs2_addr)) fwd2_p0 = mem_data;
  end

  always_comb begin
    illegal_p0 = (instr_in[1:0] != 2'b11);
    case (opc_p0)
      OPC_LOAD:   if (f3_p0 == 3'd3 || f3_p0 == 3'd6 || f3_p0 == 3'd7) illegal_p0 = 1'b1;
      OPC_FENCE, OPC_AUIPC, OPC_LUI, OPC_JAL: ;
      OPC_OPIMM:  if ((f3_p0 == 3'd1 && f7_p0 != 7'h00) ||
                      (f3_p0 == 3'd5 && f7_p0 != 7'h00 && f7_p0 != 7'h20)) illegal_p0 = 1'b1;
      OPC_STORE:  if (f3_p0 > 3'd2) illegal_p0 = 1'b1;
      OPC_OP:     if (!(f7_p0 == 7'h00 || (f7_p0 == 7'h20 && (f3_p0 == 3'd0 || f3_p0 == 3'd5))))
                    illegal_p0 = 1'b1;
      OPC_BRANCH: if (f3_p0 == 3'd2 || f3_p0 == 3'd3) illegal_p0 = 1'b1;
      OPC_JALR:   if (f3_p0 != 3'd0) illegal_p0 = 1'b1;
      default:    illegal_p0 = 1'b1;
    endcase
  end

  always_comb begin
    op1_p0    = fwd1_p0;
    op2_p0    = fwd2_p0;
    offset_p0 = '0;
    rd_p0     = instr_in[11:7];
    nop_p0    = 1'b0;
    case (opc_p0)
      OPC_OPIMM: begin
        op2_p0 = imm_i_p0;
        nop_p0 = (instr_in[31:7] == 25'd0);
      end
      OPC_LUI, OPC_AUIPC: begin
        op1_p0 = '0;
        op2_p0 = imm_u_p0;
      end
      OPC_JAL: begin
        op1_p0 = '0;
        op2_p0 = imm_j_p0;
      end
      OPC_JALR, OPC_LOAD: op2_p0 = imm_i_p0;
      OPC_BRANCH: begin
        offset_p0 = imm_b_p0;
        rd_p0     = 5'd0;
      end
      OPC_STORE: begin
        offset_p0 = imm_s_p0;
        rd_p0     = 5'd0;
      end
      OPC_FENCE: nop_p0 = 1'b1;
      default: ;
    endcase
    exc_p0 = '0;
    if (exc_in_valid) begin
      exc_p0 = exc_in;
      nop_p0 = 1'b0;
    end else if (illegal_p0) begin
      exc_p0 = EX_W'(EX_ILLEGAL);
      nop_p0 = 1'b0;
    end
  end

  // Stage boundary: decoded bundle registered toward execute.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      exc_out_valid <= 1'b0;
      nop_instr     <= 1'b0;
      stall_count   <= '0;
      pc_out        <= '0;
      opcode        <= '0;
      funct         <= '0;
      variant       <= 1'b0;
      op1           <= '0;
      op2           <= '0;
      offset        <= '0;
      rd_addr       <= '0;
      exc_out       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      exc_out_valid <= exc_in_valid || illegal_p0;
      nop_instr     <= nop_p0;
      pc_out        <= pc_in;
      opcode        <= opc_p0;
      funct         <= f3_p0;
      variant       <= instr_in[30];
      op1           <= op1_p0;
      op2           <= op2_p0;
      offset        <= offset_p0;
      rd_addr       <= rd_p0;
      exc_out       <= exc_p0;
    end else if (!out_valid || out_ready) begin
      out_valid <= 1'b0;
      if (hazard && in_valid) stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_decode_fwd.sv
// Directed bench for decode_fwd: forwarding, load-use bubble, hold, illegal decode,
// exception pass-through, flush and mid-hold reset, against hand-computed values.
module tb_decode_fwd;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic [3:0]  exc_in;
  logic        exc_in_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [4:0]  opcode;
  logic [2:0]  funct;
  logic        variant;
  logic [31:0] op1, op2, offset;
  logic [4:0]  rd_addr;
  logic        nop_instr;
  logic [3:0]  exc_out;
  logic        exc_out_valid;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        ex_wr_en, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        mem_wr_en;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        flush;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  decode_fwd dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instr_in(instr_in), .exc_in(exc_in), .exc_in_valid(exc_in_valid),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .opcode(opcode),
    .funct(funct), .variant(variant), .op1(op1), .op2(op2), .offset(offset),
    .rd_addr(rd_addr), .nop_instr(nop_instr), .exc_out(exc_out),
    .exc_out_valid(exc_out_valid), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data), .mem_wr_en(mem_wr_en),
    .mem_rd(mem_rd), .mem_data(mem_data), .flush(flush), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        exc_v;
    logic [3:0]  exc;
    logic        nop;
  } dec_vec_t;

  dec_vec_t vecs[8];

  initial begin
    reset = 1'b1; in_valid = 1'b0; pc_in = '0; instr_in = 32'h00000013;
    exc_in = '0; exc_in_valid = 1'b0; out_ready = 1'b1;
    rs1_data = '0; rs2_data = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    ex_data = '0; mem_wr_en = 1'b0; mem_rd = '0; mem_data = '0; flush = 1'b0;

    vecs[0] = '{32'hFFFFFFFF, 1'b1, 4'd2, 1'b0};
    vecs[1] = '{32'h000010E7, 1'b1, 4'd2, 1'b0};
    vecs[2] = '{32'h400060B3, 1'b1, 4'd2, 1'b0};
    vecs[3] = '{32'h400000B3, 1'b0, 4'd0, 1'b0};
    vecs[4] = '{32'h40009093, 1'b1, 4'd2, 1'b0};
    vecs[5] = '{32'h4010D093, 1'b0, 4'd0, 1'b0};
    vecs[6] = '{32'h0000000F, 1'b0, 4'd0, 1'b1};
    vecs[7] = '{32'h00000013, 1'b0, 4'd0, 1'b1};

    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_count, 0);
    check("rst_op2", op2, 0);
    check("rst_exc_v", exc_out_valid, 0);
    check("rst_nop", nop_instr, 0);
    reset = 1'b0;

    // ADDI x1,x0,5
    pc_in = 32'h100; instr_in = 32'h00500093; in_valid = 1'b1;
    #1;
    check("addi_in_ready", in_ready, 1);
    check("addi_rs2_addr", rs2_addr, 5);
    tick();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1);
    check("addi_op1", op1, 0);
    check("addi_op2", op2, 5);
    check("addi_rd", rd_addr, 1);
    check("addi_nop", nop_instr, 0);
    check("addi_funct", funct, 0);
    check("addi_opcode", opcode, 5'b00100);
    check("addi_pc", pc_out, 32'h100);

    // ADD x2,x1,x1 with EX and MEM both writing x1: EX wins
    ex_wr_en = 1'b1; ex_rd = 5'd1; ex_data = 32'hAA;
    mem_wr_en = 1'b1; mem_rd = 5'd1; mem_data = 32'hBB;
    instr_in = 32'h00108133; in_valid = 1'b1;
    #1;
    check("fwd_in_ready", in_ready, 1);
    check("fwd_rs1_addr", rs1_addr, 1);
    tick();
    check("fwd_ex_op1", op1, 32'hAA);
    check("fwd_ex_op2", op2, 32'hAA);
    check("fwd_ex_rd", rd_addr, 2);
    check("fwd_ex_stall", stall_count, 0);
    ex_wr_en = 1'b0;
    tick();
    check("fwd_mem_op1", op1, 32'hBB);
    check("fwd_mem_op2", op2, 32'hBB);
    mem_wr_en = 1'b0; rs1_data = 32'h11; rs2_data = 32'h22;
    tick();
    check("fwd_rf_op1", op1, 32'h11);
    check("fwd_rf_op2", op2, 32'h22);

    // Load-use on x1: one bubble
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    instr_in = 32'h00008133;
    #1;
    check("lu_in_ready", in_ready, 0);
    tick();
    check("lu_bubble", out_valid, 0);
    check("lu_stall", stall_count, 1);
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_rd = 5'd1; mem_data = 32'hCC;
    #1;
    check("lu_in_ready2", in_ready, 1);
    tick();
    check("lu_valid", out_valid, 1);
    check("lu_op1", op1, 32'hCC);
    check("lu_op2", op2, 0);
    check("lu_stall2", stall_count, 1);
    mem_wr_en = 1'b0;

    // LUI x5,0x12345 then hold for 3 cycles
    pc_in = 32'h200; instr_in = 32'h123452B7;
    tick();
    check("lui_valid", out_valid, 1);
    check("lui_op1", op1, 0);
    check("lui_op2", op2, 32'h12345000);
    check("lui_rd", rd_addr, 5);
    out_ready = 1'b0; pc_in = 32'h204; instr_in = 32'hFE209EE3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_in_ready", in_ready, 0);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_op2", op2, 32'h12345000);
      check("hold_rd", rd_addr, 5);
      check("hold_pc", pc_out, 32'h200);
    end
    out_ready = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();
    check("bne_valid", out_valid, 1);
    check("bne_offset", offset, 32'hFFFFFFFC);
    check("bne_rd", rd_addr, 0);
    check("bne_op1", op1, 32'h11);
    check("bne_op2", op2, 32'h22);
    check("bne_funct", funct, 1);
    check("bne_pc", pc_out, 32'h204);
    check("bne_stall", stall_count, 1);

    // Illegal / NOP decode table
    for (int i = 0; i < 8; i++) begin
      instr_in = vecs[i].instr;
      tick();
      check($sformatf("dec%0d_valid", i), out_valid, 1);
      check($sformatf("dec%0d_exc_v", i), exc_out_valid, vecs[i].exc_v);
      check($sformatf("dec%0d_exc", i), exc_out, vecs[i].exc);
      check($sformatf("dec%0d_nop", i), nop_instr, vecs[i].nop);
    end

    // Upstream exception bypasses the load-use interlock
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
    instr_in = 32'h00008133; exc_in_valid = 1'b1; exc_in = 4'd1;
    #1;
    check("excin_in_ready", in_ready, 1);
    tick();
    check("excin_exc", exc_out, 1);
    check("excin_exc_v", exc_out_valid, 1);
    check("excin_valid", out_valid, 1);
    check("excin_stall", stall_count, 1);
    ex_wr_en = 1'b0; ex_is_load = 1'b0; exc_in_valid = 1'b0; exc_in = '0;

    // Flush together with an offered instruction
    instr_in = 32'h00500093; flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_valid", out_valid, 0);
    flush = 1'b0;

    // Reset during a hold
    tick();
    check("pre_rst_valid", out_valid, 1);
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    check("pre_rst_hold", out_valid, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_stall", stall_count, 0);
    check("mid_rst_op2", op2, 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
